// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry, write-back packet and
// the EX/MEM buffer state encoding.
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [XLEN-1:0]       wdata;
  } wb_pkt_t;

  // Encoded as {skid_v, out_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_BUSY  = 2'b01,
    BUF_FULL  = 2'b11
  } buf_state_e;

endpackage

// File: rtl/skid_reg.sv
// Generic payload register with synchronous reset, clear and load.
// Clear takes priority over load.
module skid_reg #(
  parameter int unsigned W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clear_i)     data_d = '0;
    else if (load_i) data_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/ex_mem_buf.sv
// EX/MEM pipeline boundary: 2-entry skid buffer with registered ex_ready_o
// and synchronous flush. Define EX_MEM_FWD_EN to add the forwarding outputs.
module ex_mem_buf
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
`ifdef EX_MEM_FWD_EN
  output logic [ADDR_W-1:0] fwd_wd_o,
  output logic              fwd_wreg_o,
  output logic [DATA_W-1:0] fwd_wdata_o,
`endif
  output logic [DATA_W-1:0] wdata_o
);

  localparam int unsigned PW = ADDR_W + 1 + DATA_W;

  buf_state_e state_q, state_d;
  logic       ready_q, ready_d;
  logic       in_xfer, out_xfer;
  logic       out_load, out_from_skid, skid_load, slots_clear;
  logic [PW-1:0] in_pkt, out_pkt_d, out_q, skid_q;

  assign in_xfer  = ex_valid_i & ready_q;
  assign out_xfer = state_q[0] & mem_ready_i;
  assign in_pkt   = {wd_i, wreg_i, wdata_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: if (in_xfer) state_d = BUF_BUSY;
        BUF_BUSY: begin
          if (in_xfer && !out_xfer)      state_d = BUF_FULL;
          else if (!in_xfer && out_xfer) state_d = BUF_EMPTY;
        end
        BUF_FULL:  if (out_xfer) state_d = BUF_BUSY;
        default:   state_d = BUF_EMPTY;
      endcase
    end
    ready_d = (state_d != BUF_FULL);
  end

  // Flush wipes both slots; the loads are gated so a dropped input never lands.
  always_comb begin
    out_load      = 1'b0;
    out_from_skid = 1'b0;
    skid_load     = 1'b0;
    slots_clear   = flush_i;
    if (!flush_i) begin
      unique case (state_q)
        BUF_EMPTY: out_load = in_xfer;
        BUF_BUSY: begin
          out_load  = in_xfer & out_xfer;
          skid_load = in_xfer & ~out_xfer;
        end
        BUF_FULL: begin
          out_load      = out_xfer;
          out_from_skid = out_xfer;
        end
        default: ;
      endcase
    end
  end

  assign out_pkt_d = out_from_skid ? skid_q : in_pkt;

  skid_reg #(.W(PW)) u_out_slot (
    .clk     (clk),
    .rst     (rst),
    .clear_i (slots_clear),
    .load_i  (out_load),
    .d_i     (out_pkt_d),
    .q_o     (out_q)
  );

  skid_reg #(.W(PW)) u_skid_slot (
    .clk     (clk),
    .rst     (rst),
    .clear_i (slots_clear | out_from_skid),
    .load_i  (skid_load),
    .d_i     (in_pkt),
    .q_o     (skid_q)
  );

  assign ex_ready_o  = ready_q;
  assign mem_valid_o = state_q[0];
  assign wd_o        = out_q[PW-1 -: ADDR_W];
  assign wreg_o      = state_q[0] & out_q[DATA_W];
  assign wdata_o     = out_q[DATA_W-1:0];

`ifdef EX_MEM_FWD_EN
  logic [PW-1:0] young_pkt;

  assign young_pkt   = state_q[1] ? skid_q : out_q;
  assign fwd_wd_o    = young_pkt[PW-1 -: ADDR_W];
  assign fwd_wdata_o = young_pkt[DATA_W-1:0];
  assign fwd_wreg_o  = state_q[0] & young_pkt[DATA_W] & (young_pkt[PW-1 -: ADDR_W] != '0);
`endif

endmodule

// File: tb/tb_ex_mem_buf.sv
// Directed self-checking bench for ex_mem_buf (forwarding checks under EX_MEM_FWD_EN).
module tb_ex_mem_buf;
  import core_pkg::*;

  logic              clk = 1'b0;
  logic              rst, flush_i, ex_valid_i, ex_ready_o;
  logic [4:0]        wd_i, wd_o;
  logic              wreg_i, wreg_o, mem_valid_o, mem_ready_i;
  logic [31:0]       wdata_i, wdata_o;
`ifdef EX_MEM_FWD_EN
  logic [4:0]        fwd_wd_o;
  logic              fwd_wreg_o;
  logic [31:0]       fwd_wdata_o;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  ex_mem_buf #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .ex_valid_i  (ex_valid_i),
    .ex_ready_o  (ex_ready_o),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
`ifdef EX_MEM_FWD_EN
    .fwd_wd_o    (fwd_wd_o),
    .fwd_wreg_o  (fwd_wreg_o),
    .fwd_wdata_o (fwd_wdata_o),
`endif
    .wdata_o     (wdata_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input wb_pkt_t p);
    ex_valid_i = v;
    wd_i       = p.wd;
    wreg_i     = p.wreg;
    wdata_i    = p.wdata;
  endtask

  task automatic check_out(input string tag, input logic v, input wb_pkt_t p, input logic rdy);
    check({tag, "_valid"}, 64'(mem_valid_o), 64'(v));
    check({tag, "_wd"},    64'(wd_o),        64'(p.wd));
    check({tag, "_wreg"},  64'(wreg_o),      64'(p.wreg));
    check({tag, "_wdata"}, 64'(wdata_o),     64'(p.wdata));
    check({tag, "_ready"}, 64'(ex_ready_o),  64'(rdy));
  endtask

  initial begin
    wb_pkt_t pa, pb, pc, pd, pe, pn;
    pn = '0;

    rst = 1'b1; flush_i = 1'b0; mem_ready_i = 1'b0;
    drive(1'b1, '{wd: 5'd9, wreg: 1'b1, wdata: 32'h99});
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, pn);
    check_out("reset", 1'b0, pn, 1'b1);
    tick();
    check("reset_nocapture", 64'(mem_valid_o), 64'd0);

    // streaming: each word appears one edge after acceptance
    mem_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, '{wd: 5'(i), wreg: 1'b1, wdata: 32'(i * 16)});
      tick();
      check_out($sformatf("stream%0d", i), 1'b1,
                '{wd: 5'(i), wreg: 1'b1, wdata: 32'(i * 16)}, 1'b1);
    end
    drive(1'b0, pn);
    tick();
    check("stream_drain_valid", 64'(mem_valid_o), 64'd0);
    check("stream_drain_wreg",  64'(wreg_o),      64'd0);

    // back-pressure: A then B fills both slots
    pa = '{wd: 5'd3, wreg: 1'b1, wdata: 32'hAAAA};
    pb = '{wd: 5'd5, wreg: 1'b1, wdata: 32'hBBBB};
    mem_ready_i = 1'b0;
    drive(1'b1, pa); tick();
    check_out("bp_a", 1'b1, pa, 1'b1);
    drive(1'b1, pb); tick();
    check_out("bp_full", 1'b1, pa, 1'b0);
    drive(1'b0, pn); tick();
    check_out("bp_hold", 1'b1, pa, 1'b0);
    mem_ready_i = 1'b1;
    tick();
    check_out("bp_b", 1'b1, pb, 1'b1);
    // input accepted right after the drain edge
    pc = '{wd: 5'd11, wreg: 1'b1, wdata: 32'h1111};
    drive(1'b1, pc); tick();
    check_out("bp_accept", 1'b1, pc, 1'b1);
    drive(1'b0, pn); tick();
    check("bp_empty", 64'(mem_valid_o), 64'd0);

    // flush in FULL with a simultaneous input
    mem_ready_i = 1'b0;
    drive(1'b1, '{wd: 5'd1, wreg: 1'b1, wdata: 32'h1010}); tick();
    drive(1'b1, '{wd: 5'd2, wreg: 1'b1, wdata: 32'h2020}); tick();
    check("fl_full_ready", 64'(ex_ready_o), 64'd0);
    flush_i = 1'b1;
    drive(1'b1, '{wd: 5'd6, wreg: 1'b1, wdata: 32'hCCCC}); tick();
    flush_i = 1'b0;
    drive(1'b0, pn);
    check("fl_valid", 64'(mem_valid_o), 64'd0);
    check("fl_wreg",  64'(wreg_o),      64'd0);
    check("fl_ready", 64'(ex_ready_o),  64'd1);
    mem_ready_i = 1'b1;
    tick();
    check("fl_c_dropped", 64'(mem_valid_o), 64'd0);

    // simultaneous in/out while BUSY
    pd = '{wd: 5'd7, wreg: 1'b1, wdata: 32'hDDDD};
    pe = '{wd: 5'd8, wreg: 1'b1, wdata: 32'hEEEE};
    mem_ready_i = 1'b0;
    drive(1'b1, pd); tick();
    check_out("sim_d", 1'b1, pd, 1'b1);
    mem_ready_i = 1'b1;
    drive(1'b1, pe); tick();
    check_out("sim_e", 1'b1, pe, 1'b1);
    drive(1'b0, pn); tick();
    check("sim_empty", 64'(mem_valid_o), 64'd0);

    // wreg=0 entries pass through, then reset mid-operation
    mem_ready_i = 1'b0;
    drive(1'b1, '{wd: 5'd4, wreg: 1'b0, wdata: 32'h5555}); tick();
    check_out("nowreg", 1'b1, '{wd: 5'd4, wreg: 1'b0, wdata: 32'h5555}, 1'b1);
    drive(1'b1, '{wd: 5'd12, wreg: 1'b1, wdata: 32'h6666}); tick();
    check("midrst_full", 64'(ex_ready_o), 64'd0);
    rst = 1'b1; flush_i = 1'b1; tick();
    rst = 1'b0; flush_i = 1'b0;
    drive(1'b0, pn);
    check_out("midrst", 1'b0, pn, 1'b1);

`ifdef EX_MEM_FWD_EN
    check("fwd_empty_wreg", 64'(fwd_wreg_o), 64'd0);
    drive(1'b1, '{wd: 5'd2, wreg: 1'b1, wdata: 32'h2222}); tick();
    check("fwd_out_wd",    64'(fwd_wd_o),    64'd2);
    check("fwd_out_wreg",  64'(fwd_wreg_o),  64'd1);
    check("fwd_out_wdata", 64'(fwd_wdata_o), 64'h2222);
    drive(1'b1, '{wd: 5'd0, wreg: 1'b1, wdata: 32'h0F0F}); tick();
    drive(1'b0, pn);
    check("fwd_x0_wreg",  64'(fwd_wreg_o),  64'd0);
    check("fwd_x0_wdata", 64'(fwd_wdata_o), 64'h0F0F);
    mem_ready_i = 1'b1;
    tick();
    check("fwd_drain_wd",   64'(fwd_wd_o),   64'd0);
    check("fwd_drain_wreg", 64'(fwd_wreg_o), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
